// File: rtl/bram_pkg.sv
// bram_pkg: shared write-mode encodings, clear FSM states and byte-count helper
package bram_pkg;
  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;
  localparam int NO_CHANGE   = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;
  function automatic int num_bytes(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/dual_port_bram_if.sv
// dual_port_bram_if: clear control, both port buses and collision flag of the dual-port RAM
interface dual_port_bram_if import bram_pkg::*; #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 6
);
  localparam int NB = num_bytes(DATA_WIDTH);
  logic                     clr_req;
  logic                     busy;
  logic                     collision;
  logic                     read_en_a;
  logic                     read_en_b;
  logic                     write_en_a;
  logic                     write_en_b;
  logic [NB-1:0]            byte_en_a;
  logic [NB-1:0]            byte_en_b;
  logic [ADDRESS_WIDTH-1:0] addr_a;
  logic [ADDRESS_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0]    data_in_a;
  logic [DATA_WIDTH-1:0]    data_in_b;
  logic [DATA_WIDTH-1:0]    data_out_a;
  logic [DATA_WIDTH-1:0]    data_out_b;
  logic                     valid_a;
  logic                     valid_b;
  modport master (
    output clr_req, read_en_a, read_en_b, write_en_a, write_en_b,
    output byte_en_a, byte_en_b, addr_a, addr_b, data_in_a, data_in_b,
    input  busy, collision, data_out_a, data_out_b, valid_a, valid_b
  );
  modport slave (
    input  clr_req, read_en_a, read_en_b, write_en_a, write_en_b,
    input  byte_en_a, byte_en_b, addr_a, addr_b, data_in_a, data_in_b,
    output busy, collision, data_out_a, data_out_b, valid_a, valid_b
  );
endinterface

// File: rtl/bram_read_pipe.sv
// bram_read_pipe: read data/valid delay line of READ_LATENCY registers; data holds while no read flows
module bram_read_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  n_clr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);
  for (genvar s = 0; s < READ_LATENCY; s++) begin : g_st
    logic                  v;
    logic [DATA_WIDTH-1:0] d;
    logic                  v_in;
    logic [DATA_WIDTH-1:0] d_in;
    if (s == 0) begin : g_src
      assign v_in = in_valid;
      assign d_in = in_data;
    end else begin : g_src
      assign v_in = g_st[s-1].v;
      assign d_in = g_st[s-1].d;
    end
    // stage register: valid shifts every edge, data only moves alongside a valid read
    always_ff @(posedge clk or negedge n_clr)
      if (!n_clr) begin
        v <= 1'b0;
        d <= '0;
      end else begin
        v <= v_in;
        if (v_in) d <= d_in;
      end
  end
  assign out_valid = g_st[READ_LATENCY-1].v;
  assign out_data  = g_st[READ_LATENCY-1].d;
endmodule

// File: rtl/dual_port_bram.sv
// dual_port_bram: true dual-port RAM with byte enables, read-during-write modes, collision flag and clear sweep
module dual_port_bram import bram_pkg::*; #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 6,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_MODE    = READ_FIRST
) (
  input  logic              clk,
  input  logic              n_clr,
  dual_port_bram_if.slave   bus
);
  localparam int NB    = num_bytes(DATA_WIDTH);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  state_t                   state;
  state_t                   state_nxt;
  logic [ADDRESS_WIDTH-1:0] cnt;
  logic                     busy;
  logic                     wr_a;
  logic                     wr_b;
  logic                     rd_a;
  logic                     rd_b;
  logic [DATA_WIDTH-1:0]    old_a;
  logic [DATA_WIDTH-1:0]    old_b;
  logic [DATA_WIDTH-1:0]    new_a;
  logic [DATA_WIDTH-1:0]    new_b;
  logic [DATA_WIDTH-1:0]    rdata_a;
  logic [DATA_WIDTH-1:0]    rdata_b;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  // state register: reset lands in CLEAR at word 0; the counter only runs during a sweep
  always_ff @(posedge clk or negedge n_clr)
    if (!n_clr) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= busy ? cnt + 1'b1 : '0;
    end
  // next state: sweep ends after the last word, clear request only honoured when idle
  always_comb state_nxt = busy ? (&cnt ? ST_IDLE : ST_CLEAR) : (bus.clr_req ? ST_CLEAR : ST_IDLE);
  // outputs: busy for the whole sweep
  always_comb busy = state == ST_CLEAR;
  assign bus.busy = busy;
  // port qualification, byte merge and same-port read-during-write selection
  always_comb begin
    wr_a  = !busy && bus.write_en_a && |bus.byte_en_a;
    wr_b  = !busy && bus.write_en_b && |bus.byte_en_b;
    old_a = mem[bus.addr_a];
    old_b = mem[bus.addr_b];
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (bus.byte_en_a[i]) new_a[8*i +: 8] = bus.data_in_a[8*i +: 8];
      if (bus.byte_en_b[i]) new_b[8*i +: 8] = bus.data_in_b[8*i +: 8];
    end
    rd_a    = !busy && bus.read_en_a && !(WRITE_MODE == NO_CHANGE && wr_a);
    rd_b    = !busy && bus.read_en_b && !(WRITE_MODE == NO_CHANGE && wr_b);
    rdata_a = (WRITE_MODE == WRITE_FIRST && wr_a) ? new_a : old_a;
    rdata_b = (WRITE_MODE == WRITE_FIRST && wr_b) ? new_b : old_b;
  end
  // array: sweep zeroes one word per cycle; otherwise B bytes land first so A wins shared bytes
  always_ff @(posedge clk)
    if (busy) mem[cnt] <= '0;
    else
      for (int i = 0; i < NB; i++) begin
        if (wr_b && bus.byte_en_b[i]) mem[bus.addr_b][8*i +: 8] <= bus.data_in_b[8*i +: 8];
        if (wr_a && bus.byte_en_a[i]) mem[bus.addr_a][8*i +: 8] <= bus.data_in_a[8*i +: 8];
      end
  // collision flag: both ports really wrote the same word on the previous edge
  always_ff @(posedge clk or negedge n_clr)
    if (!n_clr) bus.collision <= 1'b0;
    else bus.collision <= wr_a && wr_b && bus.addr_a == bus.addr_b;
  bram_read_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_a (
    .clk      (clk),
    .n_clr    (n_clr),
    .in_valid (rd_a),
    .in_data  (rdata_a),
    .out_valid(bus.valid_a),
    .out_data (bus.data_out_a)
  );
  bram_read_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_b (
    .clk      (clk),
    .n_clr    (n_clr),
    .in_valid (rd_b),
    .in_data  (rdata_b),
    .out_valid(bus.valid_b),
    .out_data (bus.data_out_b)
  );
endmodule
